// File: rtl/mmp_i2s_tx.sv
// I2S transmitter: latches one mono sample per frame, applies mute and
// power-of-two attenuation, and sends it on both channels of a 64-slot frame.
module mmp_i2s_tx #(
    parameter int BCK_HALF = 4
) (
    input  logic               i_CLK,
    input  logic               i_RST_n,
    input  logic signed [15:0] i_DATA,
    input  logic        [3:0]  i_ATT,
    input  logic               i_MUTE,
    output logic               o_BCK,
    output logic               o_LRCK,
    output logic               o_SDATA,
    output logic               o_FRAME
);

    localparam int PW = $clog2(BCK_HALF);
    localparam logic [PW-1:0] PRE_LAST = PW'(BCK_HALF - 1);

    logic [PW-1:0]      presc;
    logic               bck_q;
    logic [5:0]         slot;
    logic signed [15:0] hold;
    logic               lrck_q;
    logic               sdata_q;
    logic               frame_q;

    logic               tick;
    logic [5:0]         slot_next;
    logic signed [15:0] sample;
    logic               slot_bit;

    // Slot data is chosen from the slot being entered, so the MSB lands one BCK after LRCK moves.
    always_comb begin
        tick      = (presc == PRE_LAST);
        slot_next = slot + 6'd1;
        sample    = i_MUTE ? 16'sd0 : (i_DATA >>> i_ATT);
        slot_bit  = 1'b0;
        if (slot_next >= 6'd1 && slot_next <= 6'd16) begin
            slot_bit = hold[4'(6'd16 - slot_next)];
        end else if (slot_next >= 6'd33 && slot_next <= 6'd48) begin
            slot_bit = hold[4'(6'd48 - slot_next)];
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            presc   <= '0;
            bck_q   <= 1'b0;
            slot    <= 6'd63;
            hold    <= '0;
            lrck_q  <= 1'b0;
            sdata_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (tick) begin
                presc <= '0;
                bck_q <= ~bck_q;
                // Everything except BCK itself only moves on the falling toggle.
                if (bck_q) begin
                    slot    <= slot_next;
                    lrck_q  <= slot_next[5];
                    sdata_q <= slot_bit;
                    if (slot == 6'd63) begin
                        hold    <= sample;
                        frame_q <= 1'b1;
                    end
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign o_BCK   = bck_q;
    assign o_LRCK  = lrck_q;
    assign o_SDATA = sdata_q;
    assign o_FRAME = frame_q;

endmodule

// File: tb/tb_mmp_i2s_tx.sv
// Self-checking bench for mmp_i2s_tx: table vectors, random frames against a
// slot-level reference model, mid-frame input change, async reset and period checks.
module tb_mmp_i2s_tx;

    logic               clk = 1'b0;
    logic               rstN;
    logic signed [15:0] dataIn;
    logic [3:0]         attIn;
    logic               muteIn;
    logic               bck, lrck, sdata, frame;
    logic               bck2, lrck2, sdata2, frame2;

    int          checkCount = 0;
    int          passCount  = 0;
    int          changeSlot = -1;
    logic [15:0] changeVal  = '0;
    int          cyc        = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  att;
        logic        mute;
        logic [15:0] expH;
    } vec_t;

    vec_t vecs[6];

    mmp_i2s_tx #(.BCK_HALF(4)) dut (
        .i_CLK(clk), .i_RST_n(rstN), .i_DATA(dataIn), .i_ATT(attIn), .i_MUTE(muteIn),
        .o_BCK(bck), .o_LRCK(lrck), .o_SDATA(sdata), .o_FRAME(frame)
    );

    mmp_i2s_tx #(.BCK_HALF(2)) dut2 (
        .i_CLK(clk), .i_RST_n(rstN), .i_DATA(dataIn), .i_ATT(attIn), .i_MUTE(muteIn),
        .o_BCK(bck2), .o_LRCK(lrck2), .o_SDATA(sdata2), .o_FRAME(frame2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic failTimeout(input string name);
        checkCount++;
        $display("[TB] FAIL %s: timed out waiting for DUT, expected event", name);
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] a, input logic m);
        dataIn = d;
        attIn  = a;
        muteIn = m;
    endtask

    // Floor-divide by 2^a, the arithmetic meaning of a sign-extending shift.
    function automatic logic [15:0] modelHold(input logic [15:0] d, input logic [3:0] a, input logic m);
        int v;
        if (m) return 16'h0000;
        v = $signed(d);
        for (int i = 0; i < int'(a); i++) v = (v < 0 && (v % 2) != 0) ? (v / 2 - 1) : (v / 2);
        return 16'(v);
    endfunction

    // Slot s occupies bit 63-s: slot 0 blank, s1..16 left word, s33..48 right word.
    function automatic logic [63:0] modelFrame(input logic [15:0] h);
        return {1'b0, h, 15'b0, 1'b0, h, 15'b0};
    endfunction

    localparam logic [63:0] LRCK_EXP = 64'h0000_0000_FFFF_FFFF;

    task automatic captureFrame(output logic [63:0] sd, output logic [63:0] lr,
                                output int extra, output bit ok);
        int   n;
        logic prevBck;
        bit   fell;
        ok = 1'b1; sd = '0; lr = '0; extra = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (frame !== 1'b1 && n < 2000);
        if (frame !== 1'b1) begin ok = 1'b0; return; end
        sd[63] = sdata; lr[63] = lrck;
        for (int s = 1; s < 64; s++) begin
            prevBck = bck;
            fell    = 1'b0;
            for (int k = 0; k < 100 && !fell; k++) begin
                @(negedge clk);
                if (frame === 1'b1) extra++;
                if (prevBck === 1'b1 && bck === 1'b0) fell = 1'b1;
                else prevBck = bck;
            end
            if (!fell) begin ok = 1'b0; return; end
            sd[63-s] = sdata; lr[63-s] = lrck;
            if (s == changeSlot) dataIn = changeVal;
        end
    endtask

    task automatic runFrame(input string name, input logic [15:0] expH);
        logic [63:0] sd, lr;
        int          extra;
        bit          ok;
        captureFrame(sd, lr, extra, ok);
        if (!ok) begin failTimeout({name, " frame"}); return; end
        checkOutput({name, " sdata"}, sd, modelFrame(expH));
        checkOutput({name, " lrck"}, lr, LRCK_EXP);
        checkOutput({name, " extra frame pulses"}, 64'(extra), 64'd0);
    endtask

    initial begin
        int          n;
        logic [7:0]  bckSeq, frSeq;
        logic        other;
        logic [15:0] rd;
        logic [3:0]  ra;
        logic        rm;
        int          tFrame[4];
        int          tRise[2];
        int          got;
        logic        prev;

        vecs[0] = '{16'h8001, 4'd0,  1'b0, 16'h8001};
        vecs[1] = '{16'h8000, 4'd1,  1'b0, 16'hC000};
        vecs[2] = '{16'h7FFF, 4'd15, 1'b0, 16'h0000};
        vecs[3] = '{16'h1234, 4'd0,  1'b1, 16'h0000};
        vecs[4] = '{16'h8000, 4'd15, 1'b0, 16'hFFFF};
        vecs[5] = '{16'h4000, 4'd2,  1'b0, 16'h1000};

        rstN = 1'b0;
        applyStimulus(vecs[0].data, vecs[0].att, vecs[0].mute);
        repeat (3) @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, vecs[i].att, vecs[i].mute);
            runFrame($sformatf("vec%0d", i), vecs[i].expH);
        end

        applyStimulus(16'h00FF, 4'd0, 1'b0);
        changeSlot = 20;
        changeVal  = 16'hFF00;
        runFrame("midchange current", 16'h00FF);
        changeSlot = -1;
        runFrame("midchange next", 16'hFF00);

        for (int i = 0; i < 10; i++) begin
            rd = 16'($urandom);
            ra = 4'($urandom_range(0, 15));
            rm = ($urandom_range(0, 3) == 0);
            applyStimulus(rd, ra, rm);
            runFrame($sformatf("rand%0d d=%h a=%0d m=%0b", i, rd, ra, rm), modelHold(rd, ra, rm));
        end

        applyStimulus(16'hFFFF, 4'd0, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(lrck === 1'b1 && bck === 1'b1) && n < 3000);
        if (!(lrck === 1'b1 && bck === 1'b1)) failTimeout("midframe reset wait");
        rstN = 1'b0;
        #1;
        checkOutput("async reset outputs", {56'b0, bck, lrck, sdata, frame, bck2, lrck2, sdata2, frame2}, 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        other = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            bckSeq[e-1] = bck;
            frSeq[e-1]  = frame;
            other       = other | lrck | sdata;
        end
        checkOutput("post-reset bck edges", 64'(bckSeq), 64'(8'b0111_1000));
        checkOutput("post-reset frame edge", 64'(frSeq), 64'(8'b1000_0000));
        checkOutput("post-reset lrck/sdata", 64'(other), 64'd0);

        n = 0;
        for (int k = 0; k < 4; k++) begin
            prev = frame2;
            do begin
                @(negedge clk); n++;
                if (frame2 === 1'b1 && prev !== 1'b1) break;
                prev = frame2;
            end while (n < 3000);
            tFrame[k] = cyc;
        end
        if (n >= 3000) failTimeout("dut2 frame pulses");
        else for (int k = 1; k < 4; k++) checkOutput($sformatf("dut2 frame interval %0d", k),
                                                      64'(tFrame[k] - tFrame[k-1]), 64'd256);

        n = 0;
        for (int k = 0; k < 2; k++) begin
            prev = bck2;
            do begin
                @(negedge clk); n++;
                if (bck2 === 1'b1 && prev === 1'b0) break;
                prev = bck2;
            end while (n < 100);
            tRise[k] = cyc;
        end
        got = tRise[1] - tRise[0];
        if (n >= 100) failTimeout("dut2 bck rises");
        else checkOutput("dut2 bck period", 64'(got), 64'd4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
